npc_mem_responder: RTL and testbench
====================================

Name: npc_mem_responder

Overview:
- Memory-side responder for the core's load/store port.
- Accepts one read or write request per transaction over a valid/ready request channel.
- Waits a programmable access latency, then performs the access against simulation memory through the existing DPI functions npcmem_read / npcmem_write.
- Returns the result on a valid/ready response channel, letting the core move from combinational DPI access to a handshaked, multi-cycle memory.

Parameters:
- LATENCY, 1: cycles from request accept to rsp_valid; legal range 1..15.
- MEM_BASE, 32'h8000_0000: lowest legal byte address.
- MEM_SIZE, 32'h0800_0000: size of legal window in bytes.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  32  write data, lane-aligned to the word
- req_wmask  in  4  byte strobes, bit i enables byte lane i
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  read word (addr & ~3); 0 for writes and errors
- rsp_err  out  1  address outside [MEM_BASE, MEM_BASE+MEM_SIZE)

Behaviour:
- Reset (rst low, asynchronous): state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared.
- Reset mid-transaction discards the pending request. No DPI call is made for it, and rsp_valid drops immediately.
- First rising edge after rst deasserts: req_ready=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready at edge N: latch addr/wen/wdata/wmask, counter <= LATENCY-1, go WAIT.
- WAIT:
  - req_ready=0.
  - If counter!=0: decrement.
  - If counter==0: perform the access at this edge, load rsp_rdata/rsp_err, go RESP.
  - Result: rsp_valid is first high in the cycle after edge N+LATENCY.
- Access rules, all evaluated on latched values:
  - Out of window: no DPI call, rsp_err=1, rsp_rdata=0.
  - Read: rsp_rdata = npcmem_read(addr & ~3), rsp_err=0. Lane extraction and sign extension stay in the core.
  - Write with wmask!=0: npcmem_write(addr & ~3, wdata, {4'b0, wmask}), rsp_rdata=0.
  - Write with wmask==0: no DPI call, normal response.
  - Exactly one DPI call per legal transaction, issued only from the clocked block, never combinationally.
- Window check is 33-bit: addr >= MEM_BASE and addr - MEM_BASE < MEM_SIZE. Wrap above 32'hFFFF_FFFF is never legal.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until handshake; req_ready=0.
  - On rsp_valid&&rsp_ready: go IDLE, rsp_valid=0 next cycle, rsp_rdata/rsp_err cleared.
- No same-cycle response-complete plus new accept. Minimum transaction period is LATENCY+2 cycles.
- req_valid while req_ready=0 is ignored. The requester must hold req_* stable until accepted.
- rsp_ready high in IDLE/WAIT has no effect.

Decomposition:
- Shared package npc_mem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - MEM_BASE / MEM_SIZE defaults
  - DPI import declarations, moved out of top so both core and responder share them
- Sub-module npc_mem_lat_counter: 4-bit loadable down-counter with load, dec, and zero flag.
- FSM, latches and DPI calls stay in npc_mem_responder.

Test Plan:
- Reset release, LATENCY=1: read 32'h8000_0000 with memory word 32'hDEAD_BEEF -> accept at edge N, rsp_valid high after edge N+1, rsp_rdata=32'hDEAD_BEEF, rsp_err=0.
- LATENCY=3, write addr 32'h8000_0006, wdata 32'h1234_0000, wmask 4'b1100 -> npcmem_write called once with (32'h8000_0004, 32'h1234_0000, 8'h0C), rsp_valid after edge N+3. A following read of 32'h8000_0004 returns the upper half 16'h1234.
- Read 32'h7FFF_FFFC and 32'h8800_0000 -> no DPI call, rsp_err=1, rsp_rdata=0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, second req_valid not accepted until the cycle after the response handshake.
- rst pulsed low during WAIT (LATENCY=4, write pending) -> outputs cleared asynchronously, no npcmem_write call, next request serviced normally.
- Write with wmask=4'b0000 -> no DPI call, rsp_valid with rsp_err=0, rsp_rdata=0.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared definitions for the load/store memory path: responder state encoding,
// default legal window, and the npcmem access functions used by core and responder.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } npc_mem_state_t;

  localparam logic [31:0] NPC_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] NPC_MEM_SIZE = 32'h0800_0000;

  // Sparse word store standing in for the simulation memory behind npcmem_*.
  logic [31:0] npcmem_data [logic [31:0]];
  int unsigned npcmem_rd_calls;
  int unsigned npcmem_wr_calls;
  logic [31:0] npcmem_last_waddr;
  logic [31:0] npcmem_last_wdata;
  logic [7:0]  npcmem_last_wmask;

  function automatic logic [31:0] npcmem_read(input logic [31:0] raddr);
    npcmem_rd_calls++;
    return npcmem_data.exists(raddr) ? npcmem_data[raddr] : 32'h0;
  endfunction

  function automatic void npcmem_write(input logic [31:0] waddr,
                                       input logic [31:0] wdata,
                                       input logic [7:0]  wmask);
    logic [31:0] word;
    word = npcmem_data.exists(waddr) ? npcmem_data[waddr] : 32'h0;
    for (int i = 0; i < 4; i++)
      if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
    npcmem_data[waddr] = word;
    npcmem_wr_calls++;
    npcmem_last_waddr = waddr;
    npcmem_last_wdata = wdata;
    npcmem_last_wmask = wmask;
  endfunction

endpackage

// File: rtl/npc_mem_lat_counter.sv
// 4-bit loadable down-counter timing the access latency; zero flags expiry.
module npc_mem_lat_counter
  import npc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/npc_mem_responder.sv
// Handshaked memory responder: latches one request, waits LATENCY cycles,
// performs a single npcmem access, then holds the response until taken.
module npc_mem_responder
  import npc_mem_pkg::*;
#(
  parameter int          LATENCY  = 1,
  parameter logic [31:0] MEM_BASE = NPC_MEM_BASE,
  parameter logic [31:0] MEM_SIZE = NPC_MEM_SIZE
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  npc_mem_state_t state;
  logic [31:0]    lat_addr;
  logic           lat_wen;
  logic [31:0]    lat_wdata;
  logic [3:0]     lat_wmask;
  logic           accept;
  logic           cnt_zero;
  logic [32:0]    addr_off;
  logic           in_window;
  logic [31:0]    word_addr;

  assign accept = (state == IDLE) && req_valid && req_ready;

  npc_mem_lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LAT_LOAD),
    .dec      (state == WAIT),
    .zero     (cnt_zero)
  );

  // 33-bit offset so a window ending at or past 2^32 can never wrap into legality.
  assign addr_off  = {1'b0, lat_addr} - {1'b0, MEM_BASE};
  assign in_window = (lat_addr >= MEM_BASE) && (addr_off < {1'b0, MEM_SIZE});
  assign word_addr = {lat_addr[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wen   <= 1'b0;
      lat_wdata <= 32'h0;
      lat_wmask <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            lat_addr  <= req_addr;
            lat_wen   <= req_wen;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            req_ready <= 1'b0;
            state     <= WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          req_ready <= 1'b0;
          if (cnt_zero) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (!in_window) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (!lat_wen) begin
              rsp_err   <= 1'b0;
              rsp_rdata <= npcmem_read(word_addr);
            end else begin
              // An all-zero strobe completes normally without touching memory.
              if (lat_wmask != 4'h0)
                npcmem_write(word_addr, lat_wdata, {4'b0000, lat_wmask});
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'h0;
            end
          end
        end
        RESP: begin
          req_ready <= 1'b0;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_responder.sv
// Directed bench for npc_mem_responder with three instances at LATENCY 1, 3 and 4.
module tb_npc_mem_responder;
  import npc_mem_pkg::*;

  logic        clk = 1'b0;
  logic [2:0]  rst_n = 3'b000;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [2:0]  req_wen = '0;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready = '0;
  logic [2:0]  rsp_err;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic [31:0] rsp_rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    npc_mem_responder #(.LATENCY(i == 0 ? 1 : (i == 1 ? 3 : 4))) u_dut (
      .clk       (clk),
      .rst       (rst_n[i]),
      .req_valid (req_valid[i]),
      .req_ready (req_ready[i]),
      .req_addr  (req_addr[i]),
      .req_wen   (req_wen[i]),
      .req_wdata (req_wdata[i]),
      .req_wmask (req_wmask[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_ready (rsp_ready[i]),
      .rsp_rdata (rsp_rdata[i]),
      .rsp_err   (rsp_err[i])
    );
  end

  // Present a request at a negedge and hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input int d, input logic [31:0] addr, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] wmask);
    req_addr[d] = addr; req_wen[d] = wen; req_wdata[d] = wdata; req_wmask[d] = wmask;
    req_valid[d] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (req_ready[d]) begin
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    checks++; errors++;
    $display("FAIL accept_timeout dut%0d: req_ready never high within 40 cycles", d);
  endtask

  // Counts cycles after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input int d, output int n);
    n = 0;
    while (!rsp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[d]) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d: rsp_valid never high within 40 cycles", d);
    end
  endtask

  task automatic complete(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_wmask[d] = 4'h0;
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || rsp_err !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b rsp_err=%b, need 000/000/000",
               req_ready, rsp_valid, rsp_err);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rsp_rdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata dut%0d: got %h need 00000000", d, rsp_rdata[d]);
      end
    end
    rst_n = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL release_before_edge: req_ready=%b need 000", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b111) begin
      errors++;
      $display("FAIL release_first_edge: req_ready=%b need 111", req_ready);
    end
  endtask

  task automatic test_read_lat1();
    int n;
    int unsigned wr0, rd0;
    wr0 = npcmem_wr_calls;
    send(0, 32'h8000_0000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(0, n);
    complete(0);
    checks++;
    if (npcmem_wr_calls - wr0 !== 1) begin
      errors++;
      $display("FAIL preload_write_calls: got %0d need 1", npcmem_wr_calls - wr0);
    end
    @(negedge clk);
    rd0 = npcmem_rd_calls;
    send(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    wait_rsp(0, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL lat1_latency: got %0d need 1", n);
    end
    checks++;
    if (rsp_rdata[0] !== 32'hDEAD_BEEF || rsp_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat1_read: rdata=%h err=%b need deadbeef/0", rsp_rdata[0], rsp_err[0]);
    end
    checks++;
    if (npcmem_rd_calls - rd0 !== 1) begin
      errors++;
      $display("FAIL lat1_read_calls: got %0d need 1", npcmem_rd_calls - rd0);
    end
    complete(0);
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat1_after_hs: valid=%b rdata=%h ready=%b need 0/00000000/1",
               rsp_valid[0], rsp_rdata[0], req_ready[0]);
    end
  endtask

  task automatic test_write_lat3();
    int n;
    int unsigned wr0;
    wr0 = npcmem_wr_calls;
    send(1, 32'h8000_0006, 1'b1, 32'h1234_0000, 4'b1100);
    wait_rsp(1, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lat3_latency: got %0d need 3", n);
    end
    checks++;
    if (npcmem_wr_calls - wr0 !== 1 || npcmem_last_waddr !== 32'h8000_0004 ||
        npcmem_last_wdata !== 32'h1234_0000 || npcmem_last_wmask !== 8'h0C) begin
      errors++;
      $display("FAIL lat3_write_call: calls=%0d addr=%h data=%h mask=%h need 1/80000004/12340000/0c",
               npcmem_wr_calls - wr0, npcmem_last_waddr, npcmem_last_wdata, npcmem_last_wmask);
    end
    checks++;
    if (rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_write_rsp: rdata=%h err=%b need 00000000/0", rsp_rdata[1], rsp_err[1]);
    end
    complete(1);
    @(negedge clk);
    send(1, 32'h8000_0004, 1'b0, 32'h0, 4'h0);
    wait_rsp(1, n);
    checks++;
    if (rsp_rdata[1] !== 32'h1234_0000) begin
      errors++;
      $display("FAIL lat3_readback: got %h need 12340000", rsp_rdata[1]);
    end
    complete(1);
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [4];
    logic        errs  [4];
    int n;
    int unsigned rd0;
    addrs[0] = 32'h7FFF_FFFC; errs[0] = 1'b1;
    addrs[1] = 32'h8800_0000; errs[1] = 1'b1;
    addrs[2] = 32'hFFFF_FFFC; errs[2] = 1'b1;
    addrs[3] = 32'h87FF_FFFC; errs[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd0 = npcmem_rd_calls;
      send(0, addrs[i], 1'b0, 32'h0, 4'h0);
      wait_rsp(0, n);
      checks++;
      if (rsp_err[0] !== errs[i] || rsp_rdata[0] !== 32'h0 ||
          (npcmem_rd_calls - rd0) !== (errs[i] ? 0 : 1)) begin
        errors++;
        $display("FAIL window_%h: err=%b rdata=%h calls=%0d need %b/00000000/%0d",
                 addrs[i], rsp_err[0], rsp_rdata[0], npcmem_rd_calls - rd0, errs[i],
                 errs[i] ? 0 : 1);
      end
      complete(0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int unsigned rd0;
    @(negedge clk);
    rd0 = npcmem_rd_calls;
    send(1, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    wait_rsp(1, n);
    req_addr[1] = 32'h8000_0004; req_wen[1] = 1'b0;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDEAD_BEEF || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d: valid=%b rdata=%h ready=%b need 1/deadbeef/0",
                 k, rsp_valid[1], rsp_rdata[1], req_ready[1]);
      end
    end
    checks++;
    if (npcmem_rd_calls - rd0 !== 1) begin
      errors++;
      $display("FAIL backpressure_calls: got %0d need 1", npcmem_rd_calls - rd0);
    end
    complete(1);
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_after_hs: valid=%b ready=%b need 0/1", rsp_valid[1], req_ready[1]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(1, n);
    checks++;
    if (n != 3 || rsp_rdata[1] !== 32'h1234_0000) begin
      errors++;
      $display("FAIL backpressure_second: lat=%0d rdata=%h need 3/12340000", n, rsp_rdata[1]);
    end
    complete(1);
  endtask

  task automatic test_reset_mid();
    int n;
    int unsigned wr0;
    @(negedge clk);
    wr0 = npcmem_wr_calls;
    send(2, 32'h8000_0010, 1'b1, 32'hAAAA_5555, 4'hF);
    @(negedge clk);
    #2 rst_n[2] = 1'b0;
    #1;
    checks++;
    if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset: ready=%b valid=%b need 0/0", req_ready[2], rsp_valid[2]);
    end
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (npcmem_wr_calls !== wr0 || rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL midwait_discard: calls=%0d valid=%b ready=%b need 0/0/1",
               npcmem_wr_calls - wr0, rsp_valid[2], req_ready[2]);
    end
    send(2, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
    wait_rsp(2, n);
    checks++;
    if (n != 4 || rsp_rdata[2] !== 32'h0 || rsp_err[2] !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_read: lat=%0d rdata=%h err=%b need 4/00000000/0",
               n, rsp_rdata[2], rsp_err[2]);
    end
    complete(2);
    @(negedge clk);
    send(2, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    wait_rsp(2, n);
    #2 rst_n[2] = 1'b0;
    #1;
    checks++;
    if (rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL resp_async_reset: valid=%b rdata=%h need 0/00000000", rsp_valid[2], rsp_rdata[2]);
    end
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_mask();
    int n;
    int unsigned wr0;
    @(negedge clk);
    wr0 = npcmem_wr_calls;
    send(0, 32'h8000_0000, 1'b1, 32'h1111_1111, 4'b0000);
    wait_rsp(0, n);
    checks++;
    if (n != 1 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || npcmem_wr_calls !== wr0) begin
      errors++;
      $display("FAIL zero_mask: lat=%0d err=%b rdata=%h calls=%0d need 1/0/00000000/0",
               n, rsp_err[0], rsp_rdata[0], npcmem_wr_calls - wr0);
    end
    complete(0);
    @(negedge clk);
    send(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    wait_rsp(0, n);
    checks++;
    if (rsp_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL zero_mask_readback: got %h need deadbeef", rsp_rdata[0]);
    end
    complete(0);
  endtask

  initial begin
    test_reset();
    test_read_lat1();
    test_write_lat3();
    test_out_of_window();
    test_backpressure();
    test_reset_mid();
    test_zero_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
